// File: rtl/glitc_config_ctrl.sv
// GLITC configuration sequencer: four independent PROGRAM_B/INIT_B/DONE FSMs behind a CTRL/STATUS bus slave.
// Bus ack one clock after strobe, one clock per access; pad inputs reach the FSMs two clocks late.
module glitc_config_ctrl #(
  parameter int PROG_CYCLES    = 64,
  parameter int INIT_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic        adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [3:0]  PROGRAM_B,
  output logic [3:0]  INIT_B_OE,
  input  logic [3:0]  INIT_B,
  input  logic [3:0]  DONE,
  output logic [3:0]  gready_o
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PROG_ASSERT = 3'd1,
    ST_INIT_HOLD   = 3'd2,
    ST_WAIT_INIT   = 3'd3,
    ST_LOADING     = 3'd4,
    ST_READY       = 3'd5,
    ST_ERROR       = 3'd6
  } state_t;

  localparam int MAX_PI  = (PROG_CYCLES > INIT_CYCLES) ? PROG_CYCLES : INIT_CYCLES;
  localparam int MAX_ALL = (MAX_PI > TIMEOUT_CYCLES) ? MAX_PI : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam logic [CW-1:0] PROG_LOAD = CW'(PROG_CYCLES - 1);
  localparam logic [CW-1:0] INIT_LOAD = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD   = CW'(TIMEOUT_CYCLES - 1);

  logic [3:0]  r_init_meta, r_init_sync, r_done_meta, r_done_sync;
  logic        r_ack, r_held;
  logic [31:0] r_dat;
  logic        w_req, w_acc, w_cmd, w_unused_dat;
  logic [3:0]  w_start, w_abort;
  logic [3:0]  w_program_b, w_init_oe, w_gready;
  logic [2:0]  w_state_code [4];
  logic [31:0] w_status;

  // A strobe held past its ack is the same access, so it must not re-issue commands.
  assign w_req        = cyc_i & stb_i;
  assign w_acc        = w_req & ~r_ack;
  assign w_cmd        = w_acc & we_i & ~adr_i & ~r_held;
  assign w_start      = {4{w_cmd}} & dat_i[3:0];
  assign w_abort      = {4{w_cmd}} & dat_i[7:4];
  assign w_unused_dat = ^dat_i[31:8];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_init_meta <= '0;
      r_init_sync <= '0;
      r_done_meta <= '0;
      r_done_sync <= '0;
    end else begin
      r_init_meta <= INIT_B;
      r_init_sync <= r_init_meta;
      r_done_meta <= DONE;
      r_done_sync <= r_done_meta;
    end
  end

  always_comb begin
    w_status = '0;
    for (int g = 0; g < 4; g++) begin
      w_status[4*g +: 3] = w_state_code[g];
    end
    w_status[19:16] = w_gready;
    w_status[23:20] = r_done_sync;
    w_status[27:24] = r_init_sync;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ack  <= 1'b0;
      r_held <= 1'b0;
      r_dat  <= '0;
    end else begin
      r_ack  <= w_acc;
      r_held <= w_req & (r_held | w_acc);
      r_dat  <= (w_acc & ~we_i & adr_i) ? w_status : '0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_fsm
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_prog_b, r_oe, r_rdy;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_prog_b <= 1'b1;
        r_oe     <= 1'b0;
        r_rdy    <= 1'b0;
      end else if (w_abort[g]) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_prog_b <= 1'b1;
        r_oe     <= 1'b0;
        r_rdy    <= 1'b0;
      end else if (w_start[g]) begin
        r_state  <= ST_PROG_ASSERT;
        r_cnt    <= PROG_LOAD;
        r_prog_b <= 1'b0;
        r_oe     <= 1'b0;
        r_rdy    <= 1'b0;
      end else begin
        // Counter is loaded with N-1 on entry so each phase lasts exactly N clocks.
        case (r_state)
          ST_PROG_ASSERT: begin
            if (r_cnt == '0) begin
              r_state  <= ST_INIT_HOLD;
              r_cnt    <= INIT_LOAD;
              r_prog_b <= 1'b1;
              r_oe     <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          ST_INIT_HOLD: begin
            if (r_cnt == '0) begin
              r_state <= ST_WAIT_INIT;
              r_cnt   <= TO_LOAD;
              r_oe    <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          ST_WAIT_INIT: begin
            if (r_init_sync[g]) begin
              r_state <= ST_LOADING;
              r_cnt   <= TO_LOAD;
            end else if (r_cnt == '0) begin
              r_state <= ST_ERROR;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          ST_LOADING: begin
            if (r_done_sync[g]) begin
              r_state <= ST_READY;
              r_cnt   <= '0;
              r_rdy   <= 1'b1;
            end else if (!r_init_sync[g] || r_cnt == '0) begin
              r_state <= ST_ERROR;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          ST_READY: begin
            if (!r_done_sync[g]) begin
              r_state <= ST_IDLE;
              r_rdy   <= 1'b0;
            end
          end
          ST_IDLE, ST_ERROR: begin
            r_cnt <= '0;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_prog_b <= 1'b1;
            r_oe     <= 1'b0;
            r_rdy    <= 1'b0;
          end
        endcase
      end
    end

    assign w_state_code[g] = r_state;
    assign w_program_b[g]  = r_prog_b;
    assign w_init_oe[g]    = r_oe;
    assign w_gready[g]     = r_rdy;
  end

  assign PROGRAM_B = w_program_b;
  assign INIT_B_OE = w_init_oe;
  assign gready_o  = w_gready;
  assign ack_o     = r_ack;
  assign dat_o     = r_dat;

endmodule

// File: tb/tb_glitc_config_ctrl.sv
// Directed bench for glitc_config_ctrl with short phase parameters (4/4/32).
module tb_glitc_config_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we, adr;
  logic [31:0] dat_w;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [3:0]  program_b, init_b_oe, init_b, done, gready;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] init_b;
    logic [3:0] done;
    logic       exp_pb0;
    logic       exp_oe0;
    logic       exp_rdy0;
  } vec_t;

  vec_t vecs [28];

  always #5 clk = ~clk;

  glitc_config_ctrl #(
    .PROG_CYCLES   (4),
    .INIT_CYCLES   (4),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .cyc_i    (cyc),
    .stb_i    (stb),
    .we_i     (we),
    .adr_i    (adr),
    .dat_i    (dat_w),
    .dat_o    (dat_o),
    .ack_o    (ack_o),
    .PROGRAM_B(program_b),
    .INIT_B_OE(init_b_oe),
    .INIT_B   (init_b),
    .DONE     (done),
    .gready_o (gready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 1'b0; dat_w = d;
    @(negedge clk);
    chk("wr_ack", ack_o, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(negedge clk);
    chk("rd_ack", ack_o, 1);
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_gready(input logic [3:0] m, input string nm);
    int k = 0;
    while ((gready & m) !== m && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, gready & m, m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    for (int c = 0; c < 28; c++) begin
      vecs[c].init_b   = (c >= 11) ? 4'b0001 : 4'b0000;
      vecs[c].done     = (c >= 21) ? 4'b0001 : 4'b0000;
      vecs[c].exp_pb0  = (c >= 4);
      vecs[c].exp_oe0  = (c >= 4 && c < 8);
      vecs[c].exp_rdy0 = (c >= 24);
    end

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0; dat_w = '0;
    init_b = '0; done = '0;
    repeat (3) @(negedge clk);
    chk("rst_program_b", program_b, 4'hF);
    chk("rst_init_b_oe", init_b_oe, 4'h0);
    chk("rst_gready", gready, 4'h0);
    chk("rst_ack", ack_o, 0);
    chk("rst_dat", dat_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full bring-up of GLITC 0, checked clock by clock from the write.
    bus_wr(32'h1);
    for (int c = 0; c < 28; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("v%0d_pb0", c), program_b[0], vecs[c].exp_pb0);
      chk($sformatf("v%0d_oe0", c), init_b_oe[0], vecs[c].exp_oe0);
      chk($sformatf("v%0d_rdy0", c), gready[0], vecs[c].exp_rdy0);
      init_b = vecs[c].init_b;
      done   = vecs[c].done;
    end
    bus_rd(1'b1, rd);
    chk("g0_ready_status", rd, 32'h0111_0005);

    // GLITC 1: DONE never rises, LOADING must time out after exactly 32 clocks.
    @(negedge clk);
    init_b = 4'b0011;
    bus_wr(32'h2);
    repeat (39) @(negedge clk);
    bus_rd(1'b1, rd);
    chk("g1_loading_at39", rd[6:4], 3'd4);
    @(negedge clk);
    bus_rd(1'b1, rd);
    chk("g1_error_at41", rd[6:4], 3'd6);
    chk("g1_gready", gready[1], 0);

    // GLITC 2 to READY, then start+abort in one write.
    @(negedge clk);
    init_b = 4'b0111;
    bus_wr(32'h4);
    repeat (12) @(negedge clk);
    done = 4'b0101;
    wait_gready(4'b0100, "g2_ready_wait");
    bus_wr(32'h44);
    chk("g2_abort_gready", gready[2], 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("g2_abort_pb%0d", k), program_b[2], 1);
      @(negedge clk);
    end
    bus_rd(1'b1, rd);
    chk("g2_abort_status", rd, 32'h0751_0065);

    // All four READY, then DONE[3] drops.
    @(negedge clk);
    init_b = 4'b1111;
    done   = 4'b0001;
    bus_wr(32'hE);
    repeat (12) @(negedge clk);
    done = 4'b1111;
    wait_gready(4'b1111, "all_ready_wait");
    bus_rd(1'b1, rd);
    chk("all_ready_status", rd, 32'h0FFF_5555);
    done = 4'b0111;
    @(negedge clk);
    chk("done3_drop_t1", gready, 4'b1111);
    @(negedge clk);
    chk("done3_drop_t2", gready, 4'b1111);
    @(negedge clk);
    chk("done3_drop_t3", gready, 4'b0111);
    bus_rd(1'b1, rd);
    chk("done3_drop_status", rd, 32'h0F77_0555);

    // Reset during PROG_ASSERT with a bus read in flight.
    @(negedge clk);
    bus_wr(32'h1);
    chk("restart_pb", program_b, 4'b1110);
    rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 1'b1;
    init_b = '0; done = '0;
    @(negedge clk);
    chk("midrst_pb", program_b, 4'hF);
    chk("midrst_oe", init_b_oe, 4'h0);
    chk("midrst_gready", gready, 4'h0);
    chk("midrst_ack", ack_o, 0);
    chk("midrst_dat", dat_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(negedge clk);
    bus_rd(1'b1, rd);
    chk("postrst_status", rd, 32'h0);
    @(negedge clk);
    bus_rd(1'b0, rd);
    chk("ctrl_read", rd, 32'h0);

    // Held write strobe: ack alternates, start issued only once.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 1'b0; dat_w = 32'h1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("held_ack%0d", k), ack_o, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("held_pb0_%0d", k), program_b[0], (k <= 4) ? 0 : 1);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("held_ack6", ack_o, 0);
    chk("held_pb0_6", program_b[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
